imem_boot_loader: RTL
=====================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter PC_SIZE, default 10, the instruction-memory address width (depth 2^PC_SIZE words).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-005 SHALL have port load_len  input  PC_SIZE+1  number of words to load, sampled when start=1.
REQ-006 SHALL have port abort  input  1  cancels a load in progress.
REQ-007 SHALL have port s_valid  input  1  host word valid.
REQ-008 SHALL have port s_data  input  32  host instruction word.
REQ-009 SHALL have port s_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port imem_rw  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_reset_memory  output  1  instruction-memory clear strobe.
REQ-012 SHALL have port imem_write_addr  output  PC_SIZE  instruction-memory write address.
REQ-013 SHALL have port imem_instruction  output  32  instruction-memory write data.
REQ-014 SHALL have port core_reset  output  1  1 = hold the fetch stage/PC in reset.
REQ-015 SHALL have port busy  output  1  1 in CLEAR, LOAD, FLUSH.
REQ-016 SHALL have port done  output  1  one-cycle pulse on entry to RUN.
REQ-017 SHALL have port error  output  1  one-cycle pulse on rejected start or abort.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, LOAD, FLUSH, RUN; all outputs registered except s_ready, which is decoded from state (s_ready=1 iff state=LOAD).
REQ-019 IDLE: core_reset=1; start with 1<=load_len<=2^PC_SIZE SHALL latch load_len, zero the word counter and go to CLEAR; any other load_len SHALL pulse error and remain in IDLE.
REQ-020 CLEAR SHALL last exactly one cycle with imem_reset_memory=1, then go to LOAD.
REQ-021 LOAD: a word is accepted on an edge where s_valid=1 and s_ready=1; the following cycle SHALL present imem_rw=1, imem_write_addr=counter value at acceptance, imem_instruction=accepted s_data (write latency 1 cycle).
REQ-022 Counter SHALL increment by 1 per accepted word; imem_rw SHALL be 0 in any cycle not following an acceptance.
REQ-023 Acceptance of word number load_len-1 SHALL move LOAD->FLUSH; FLUSH lasts one cycle (carries the last write), then RUN.
REQ-024 load_len=2^PC_SIZE SHALL write addresses 0..2^PC_SIZE-1 with no address wrap and no extra write.
REQ-025 RUN: core_reset=0, done=1 in the first RUN cycle only; s_valid ignored.
REQ-026 start in RUN with valid load_len SHALL set core_reset=1 on the next edge and enter CLEAR; invalid load_len pulses error and stays in RUN.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in CLEAR or LOAD SHALL go to IDLE next edge with error=1 for one cycle; a write already scheduled from the aborting cycle's acceptance SHALL NOT be issued; abort in FLUSH is ignored; abort has priority over acceptance in the same cycle.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, counter=0, core_reset=1, imem_rw=0, imem_reset_memory=0, imem_write_addr=0, imem_instruction=0, busy=0, done=0, error=0, s_ready=0, regardless of clock.
REQ-030 Reset asserted mid-LOAD SHALL drop any pending write; after release the block waits in IDLE for start.

Verification
REQ-031 PC_SIZE=10, start, load_len=3, words 0xA,0xB,0xC back-to-back -> CLEAR pulse 1 cycle; imem_rw at addr 0,1,2 with 0xA,0xB,0xC on consecutive cycles; FLUSH; done pulse; core_reset 1->0.
REQ-032 Same load with s_valid gaps of 2 cycles -> writes only after accepted words, addresses contiguous, no spurious imem_rw.
REQ-033 start with load_len=0, then load_len=1025 -> error pulse each time, state IDLE, core_reset=1, no imem strobe.
REQ-034 abort asserted together with acceptance of word 2 of 5 -> error pulse, IDLE, only addr 0,1 written.
REQ-035 RUN then start load_len=1024 -> core_reset=1 next edge, 1024 writes addr 0..1023, done pulse, core_reset=0.
REQ-036 reset=0 between clock edges mid-LOAD -> all outputs at reset values before next edge; no write after release.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles everything the boot loader exchanges with the host and with the
// instruction memory / fetch stage. Clock and reset stay as plain ports.
//
//   start, load_len, abort    host load control
//   s_valid, s_data, s_ready  host word stream (ready/valid)
//   imem_rw, imem_reset_memory,
//   imem_write_addr, imem_instruction
//                             instruction-memory write/clear port
//   core_reset                holds the fetch stage / PC in reset
//   busy, done, error         status
//
// Modports: slave = the loader, master = the host/system side.
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int PC_SIZE = 10
);
    logic               start;
    logic [PC_SIZE:0]   load_len;
    logic               abort;
    logic               s_valid;
    logic [31:0]        s_data;
    logic               s_ready;
    logic               imem_rw;
    logic               imem_reset_memory;
    logic [PC_SIZE-1:0] imem_write_addr;
    logic [31:0]        imem_instruction;
    logic               core_reset;
    logic               busy;
    logic               done;
    logic               error;

    modport slave (
        input  start, load_len, abort, s_valid, s_data,
        output s_ready, imem_rw, imem_reset_memory, imem_write_addr,
               imem_instruction, core_reset, busy, done, error
    );

    modport master (
        output start, load_len, abort, s_valid, s_data,
        input  s_ready, imem_rw, imem_reset_memory, imem_write_addr,
               imem_instruction, core_reset, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Loads a program of load_len 32-bit words from a host stream into the
// instruction memory, starting at address 0, while holding the core in
// reset. Sequence: IDLE -> CLEAR (one-cycle memory clear) -> LOAD (accept
// words) -> FLUSH (last write lands) -> RUN (core released).
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    imem_boot_loader_if.slave (control, host stream, imem port,
//          status)
//
// All outputs are registered except s_ready, which is decoded from state.
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int PC_SIZE = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    imem_boot_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        RUN   = 3'd4
    } state_t;

    // Largest legal load: the whole memory.
    localparam logic [PC_SIZE:0] MAX_LEN = {1'b1, {PC_SIZE{1'b0}}};
    localparam logic [PC_SIZE:0] ONE     = {{PC_SIZE{1'b0}}, 1'b1};

    state_t             state_reg;
    logic [PC_SIZE:0]   count_reg;
    logic [PC_SIZE:0]   len_reg;
    logic               rw_reg;
    logic               clear_reg;
    logic [PC_SIZE-1:0] addr_reg;
    logic [31:0]        instr_reg;
    logic               core_reset_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               error_reg;

    logic len_ok;
    logic last_word;

    assign len_ok    = (bus.load_len != '0) && (bus.load_len <= MAX_LEN);
    // Counter is one bit wider than the address so a full-memory load
    // terminates on word 2^PC_SIZE-1 without wrapping.
    assign last_word = (count_reg == (len_reg - ONE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            len_reg        <= '0;
            rw_reg         <= 1'b0;
            clear_reg      <= 1'b0;
            addr_reg       <= '0;
            instr_reg      <= '0;
            core_reset_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rw_reg    <= 1'b0;
            clear_reg <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;

            case (state_reg)
                IDLE, RUN: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            len_reg        <= bus.load_len;
                            count_reg      <= '0;
                            clear_reg      <= 1'b1;
                            core_reset_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            state_reg      <= CLEAR;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    if (bus.abort) begin
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= LOAD;
                    end
                end

                LOAD: begin
                    // Abort wins over a word offered in the same cycle, so
                    // that word is neither counted nor written.
                    if (bus.abort) begin
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (bus.s_valid) begin
                        rw_reg    <= 1'b1;
                        addr_reg  <= count_reg[PC_SIZE-1:0];
                        instr_reg <= bus.s_data;
                        count_reg <= count_reg + ONE;
                        if (last_word) begin
                            state_reg <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    // The final write is on the bus this cycle; abort is
                    // deliberately not looked at here.
                    core_reset_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b1;
                    state_reg      <= RUN;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready           = (state_reg == LOAD);
    assign bus.imem_rw           = rw_reg;
    assign bus.imem_reset_memory = clear_reg;
    assign bus.imem_write_addr   = addr_reg;
    assign bus.imem_instruction  = instr_reg;
    assign bus.core_reset        = core_reset_reg;
    assign bus.busy              = busy_reg;
    assign bus.done              = done_reg;
    assign bus.error             = error_reg;

endmodule
